rx_control: RTL and testbench

RX_CONTROL -- requirements
Module: rx_control

---
 rtl/rx_control.sv | 252 +++++++++++++++++++++++++
 tb/tb_rx_control.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_control.sv
// UART receiver (16x oversampled, LSB-first) feeding a byte FIFO read over MMIO.
// Optional even-parity frame checking is enabled by defining RX_PARITY_EN.
module rx_control #(
    parameter int BAUD_DIV = 54,
    parameter int DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [31:0]              rd_data,
    output logic                     rd_valid,
    output logic                     rx_empty,
    output logic                     rx_full,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic                     overrun,
    output logic                     frame_err
`ifdef RX_PARITY_EN
    ,
    output logic                     parity_err
`endif
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic          r_rx_meta;
    logic          r_rx_s;
    logic [BW-1:0] r_baud_cnt;
    logic          w_tick;

    state_t        r_state, w_state_next;
    logic [3:0]    r_sample_cnt, w_sample_next;
    logic [2:0]    r_bit_cnt, w_bit_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          w_push;
    logic          w_frame_set;
`ifdef RX_PARITY_EN
    logic          r_par_bad, w_par_bad_next;
    logic          w_parity_set;
    logic          r_parity_err;
`endif

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic          w_overrun_set;
    logic [31:0]   r_rd_data;
    logic          r_rd_valid;
    logic          r_overrun;
    logic          r_frame_err;

    // Synchronizer idles high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick = (r_baud_cnt == BW'(BAUD_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)
            r_baud_cnt <= '0;
        else if (w_tick)
            r_baud_cnt <= '0;
        else
            r_baud_cnt <= r_baud_cnt + BW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
`ifdef RX_PARITY_EN
            r_par_bad    <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_sample_cnt <= w_sample_next;
            r_bit_cnt    <= w_bit_next;
            r_shift      <= w_shift_next;
`ifdef RX_PARITY_EN
            r_par_bad    <= w_par_bad_next;
`endif
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_sample_next = r_sample_cnt;
        w_bit_next    = r_bit_cnt;
        w_shift_next  = r_shift;
        w_push        = 1'b0;
        w_frame_set   = 1'b0;
`ifdef RX_PARITY_EN
        w_par_bad_next = r_par_bad;
        w_parity_set   = 1'b0;
`endif
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (!r_rx_s) begin
                        w_state_next  = START;
                        w_sample_next = '0;
                    end
                end
                // Mid-start recheck rejects pulses shorter than half a bit.
                START: begin
                    if (r_sample_cnt == 4'd7) begin
                        w_sample_next = '0;
                        if (!r_rx_s) begin
                            w_state_next = DATA;
                            w_bit_next   = '0;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_sample_next = r_sample_cnt + 4'd1;
                    end
                end
                DATA: begin
                    w_sample_next = r_sample_cnt + 4'd1;
                    if (r_sample_cnt == 4'd15) begin
                        w_shift_next = {r_rx_s, r_shift[7:1]};
                        w_bit_next   = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef RX_PARITY_EN
                            w_state_next = PARITY;
`else
                            w_state_next = STOP;
`endif
                        end
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    w_sample_next = r_sample_cnt + 4'd1;
                    if (r_sample_cnt == 4'd15) begin
                        w_par_bad_next = (^r_shift) ^ r_rx_s;
                        w_state_next   = STOP;
                    end
                end
`endif
                STOP: begin
                    w_sample_next = r_sample_cnt + 4'd1;
                    if (r_sample_cnt == 4'd15) begin
                        w_state_next = IDLE;
                        w_frame_set  = !r_rx_s;
`ifdef RX_PARITY_EN
                        w_parity_set = r_par_bad;
                        w_push       = r_rx_s && !r_par_bad;
`else
                        w_push       = r_rx_s;
`endif
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    assign w_empty       = (r_count == '0);
    assign w_full        = (r_count == CW'(DEPTH));
    assign w_pop         = rd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr          = w_push && (!w_full || w_pop);
    assign w_overrun_set = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count    <= r_count + CW'(w_wr) - CW'(w_pop);
            r_rd_valid <= rd_en;
            if (w_pop)
                r_rd_data <= {24'b0, r_mem[r_rd_ptr]};
            else if (rd_en)
                r_rd_data <= '0;
        end
    end

    // Sticky flags: a set in the same cycle as clr_err takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            if (w_overrun_set)
                r_overrun <= 1'b1;
            else if (clr_err)
                r_overrun <= 1'b0;
            if (w_frame_set)
                r_frame_err <= 1'b1;
            else if (clr_err)
                r_frame_err <= 1'b0;
`ifdef RX_PARITY_EN
            if (w_parity_set)
                r_parity_err <= 1'b1;
            else if (clr_err)
                r_parity_err <= 1'b0;
`endif
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign rx_empty  = w_empty;
    assign rx_full   = w_full;
    assign rx_count  = r_count;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
`ifdef RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_rx_control.sv
// Directed bench for rx_control at BAUD_DIV=4 (64 clk per bit), DEPTH=16.
// Parity scenarios are compiled in only when RX_PARITY_EN is defined.
module tb_rx_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        rd_en;
    logic        clr_err;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rx_empty;
    logic        rx_full;
    logic [4:0]  rx_count;
    logic        overrun;
    logic        frame_err;
`ifdef RX_PARITY_EN
    logic        parity_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rx_control #(.BAUD_DIV(4), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rx_empty  (rx_empty),
        .rx_full   (rx_full),
        .rx_count  (rx_count),
        .overrun   (overrun),
        .frame_err (frame_err)
`ifdef RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    task automatic send_bit(input logic v);
        rx = v;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef RX_PARITY_EN
        send_bit(^b);
`endif
        send_bit(stop_b);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        $display("frame: byte=%02h stop=%0b count=%0d", b, stop_b, rx_count);
    endtask

    // One-cycle rd_en pulse; returns at the negedge after the popping edge.
    task automatic do_read();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        $display("read: valid=%0b data=%08h count=%0d", rd_valid, rd_data, rx_count);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got %08h want 00000000", rd_data); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", rx_empty); end
        n_checks++; if (rx_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", rx_full); end
        n_checks++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", rx_count); end
        n_checks++; if ({overrun, frame_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {overrun, frame_err}); end
    endtask

    task automatic test_single_byte();
        send_frame(8'hA5, 1'b1);
        n_checks++; if (rx_count !== 5'd1) begin n_fail++; $display("FAIL a5_count got %0d want 1", rx_count); end
        n_checks++; if (rx_empty !== 1'b0) begin n_fail++; $display("FAIL a5_not_empty got %b want 0", rx_empty); end
        do_read();
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL a5_valid got %b want 1", rd_valid); end
        n_checks++; if (rd_data !== 32'h000000A5) begin n_fail++; $display("FAIL a5_data got %08h want 000000a5", rd_data); end
        n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL a5_empty_after got %b want 1", rx_empty); end
        @(negedge clk);
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL a5_valid_drop got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== 32'h000000A5) begin n_fail++; $display("FAIL a5_data_hold got %08h want 000000a5", rd_data); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (120) @(negedge clk);
        $display("glitch: 20 clk low, count=%0d", rx_count);
        n_checks++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL glitch_count got %0d want 0", rx_count); end
        n_checks++; if ({overrun, frame_err} !== 2'b00) begin n_fail++; $display("FAIL glitch_flags got %b want 00", {overrun, frame_err}); end
        send_frame(8'h5A, 1'b1);
        do_read();
        n_checks++; if (rd_data !== 32'h0000005A) begin n_fail++; $display("FAIL glitch_recover got %08h want 0000005a", rd_data); end
    endtask

    task automatic test_frame_err();
        send_frame(8'h3C, 1'b0);
        repeat (64) @(negedge clk);
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set got %b want 1", frame_err); end
        n_checks++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL ferr_count got %0d want 0", rx_count); end
        pulse_clr();
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear got %b want 0", frame_err); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        n_checks++; if (rx_count !== 5'd2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", rx_count); end
        do_read();
        n_checks++; if (rd_data !== 32'h00000012) begin n_fail++; $display("FAIL b2b_first got %08h want 00000012", rd_data); end
        do_read();
        n_checks++; if (rd_data !== 32'h00000034) begin n_fail++; $display("FAIL b2b_second got %08h want 00000034", rd_data); end
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b want 1", rd_valid); end
    endtask

    task automatic test_overrun();
        logic [7:0] b;
        for (int i = 0; i < 17; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1);
        end
        n_checks++; if (rx_full !== 1'b1) begin n_fail++; $display("FAIL ovr_full got %b want 1", rx_full); end
        n_checks++; if (rx_count !== 5'd16) begin n_fail++; $display("FAIL ovr_count got %0d want 16", rx_count); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag got %b want 1", overrun); end
        for (int i = 0; i < 16; i++) begin
            do_read();
            n_checks++; if (rd_data !== 32'(i)) begin n_fail++; $display("FAIL ovr_read%0d got %08h want %08h", i, rd_data, 32'(i)); end
        end
        n_checks++; if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL ovr_empty got %b want 1", rx_empty); end
        do_read();
        n_checks++; if ({rd_valid, rd_data} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL ovr_empty_read got valid=%b data=%08h want valid=1 data=00000000", rd_valid, rd_data); end
        n_checks++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL ovr_empty_ptr got %0d want 0", rx_count); end
        pulse_clr();
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", overrun); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'hF0;
        send_frame(8'h99, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(b[i]);
        rst = 1'b1; rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("reset: mid-frame, count=%0d", rx_count);
        n_checks++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", rx_count); end
        n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL midrst_rd_data got %08h want 00000000", rd_data); end
        repeat (100) @(negedge clk);
        send_frame(8'h81, 1'b1);
        n_checks++; if (rx_count !== 5'd1) begin n_fail++; $display("FAIL midrst_after_count got %0d want 1", rx_count); end
        do_read();
        n_checks++; if (rd_data !== 32'h00000081) begin n_fail++; $display("FAIL midrst_data got %08h want 00000081", rd_data); end
        n_checks++; if ({overrun, frame_err} !== 2'b00) begin n_fail++; $display("FAIL midrst_flags got %b want 00", {overrun, frame_err}); end
    endtask

`ifdef RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] b, input logic par_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par_b);
        send_bit(1'b1);
        repeat (8) @(negedge clk);
        $display("frame: byte=%02h parity=%0b count=%0d", b, par_b, rx_count);
    endtask

    task automatic test_parity();
        send_frame_par(8'h07, 1'b0);
        n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL par_err_set got %b want 1", parity_err); end
        n_checks++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL par_bad_count got %0d want 0", rx_count); end
        pulse_clr();
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL par_clear got %b want 0", parity_err); end
        send_frame_par(8'h07, 1'b1);
        n_checks++; if (rx_count !== 5'd1) begin n_fail++; $display("FAIL par_good_count got %0d want 1", rx_count); end
        do_read();
        n_checks++; if (rd_data !== 32'h00000007) begin n_fail++; $display("FAIL par_good_data got %08h want 00000007", rd_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_overrun();
        test_reset_mid_frame();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
